aes_encrypt_iter: RTL

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_enc_round.sv | 44 ++++
 rtl/aes_encrypt_iter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the encryption and decryption round chains:
// S-box and Rcon tables, round count, block type and byte-level helpers.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by round number 1..10; entries outside that range are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the last round) and AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  aes_block_t state_in,
    input  aes_block_t round_key,
    input  logic       last_round,
    output aes_block_t state_out
);

    logic [7:0] sb_s [16];
    logic [7:0] sr_s [16];
    logic [7:0] mc_s [16];
    aes_block_t pre_key_s;

    // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb_s[i] = SBOX[state_in[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_s[4*c+0] = xtime(sr_s[4*c+0]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
            mc_s[4*c+3] = xtime(sr_s[4*c+0]) ^ sr_s[4*c+0] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
        end
        pre_key_s = '0;
        for (int i = 0; i < 16; i++) begin
            if (last_round) begin
                pre_key_s[127-8*i -: 8] = sr_s[i];
            end else begin
                pre_key_s[127-8*i -: 8] = mc_s[i];
            end
        end
        state_out = pre_key_s ^ round_key;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per cycle, round keys expanded on the fly.
// Define AES_KEYOUT_EN to expose the round-10 key on last_key.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
`ifdef AES_KEYOUT_EN
    ,
    output logic [127:0] last_key
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

    logic [1:0] fsm_r;
    logic [3:0] round_r;
    aes_block_t state_r;
    aes_block_t rkey_r;
    aes_block_t ciphertext_r;
    logic       in_ready_r;
    logic       out_valid_r;
`ifdef AES_KEYOUT_EN
    aes_block_t last_key_r;
`endif

    logic [31:0] w0_s, w1_s, w2_s, w3_s, temp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;
    aes_block_t  next_key_s;
    aes_block_t  round_out_s;
    logic        last_round_s;

    // Next round key from the current one: RotWord, SubWord, Rcon[round].
    always_comb begin
        w0_s         = rkey_r[127:96];
        w1_s         = rkey_r[95:64];
        w2_s         = rkey_r[63:32];
        w3_s         = rkey_r[31:0];
        temp_s       = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {RCON[round_r], 24'h000000};
        n0_s         = w0_s ^ temp_s;
        n1_s         = w1_s ^ n0_s;
        n2_s         = w2_s ^ n1_s;
        n3_s         = w3_s ^ n2_s;
        next_key_s   = {n0_s, n1_s, n2_s, n3_s};
        last_round_s = (round_r == LAST_ROUND);
    end

    aes_enc_round u_round (
        .state_in   (state_r),
        .round_key  (next_key_s),
        .last_round (last_round_s),
        .state_out  (round_out_s)
    );

    // Control FSM and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r        <= ST_IDLE;
            round_r      <= 4'd0;
            state_r      <= '0;
            rkey_r       <= '0;
            ciphertext_r <= '0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
`ifdef AES_KEYOUT_EN
            last_key_r   <= '0;
`endif
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r    <= plaintext ^ key;
                        rkey_r     <= key;
                        round_r    <= 4'd1;
                        fsm_r      <= ST_BUSY;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    state_r <= round_out_s;
                    rkey_r  <= next_key_s;
                    if (last_round_s) begin
                        round_r      <= 4'd0;
                        fsm_r        <= ST_DONE;
                        ciphertext_r <= round_out_s;
                        out_valid_r  <= 1'b1;
`ifdef AES_KEYOUT_EN
                        last_key_r   <= next_key_s;
`endif
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low on this edge; next accept is a cycle later.
                    if (out_ready) begin
                        fsm_r       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    round_r     <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign ciphertext = ciphertext_r;
`ifdef AES_KEYOUT_EN
    assign last_key   = last_key_r;
`endif

endmodule
